// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control unit: STOP/RUN/CLEAR/VIEW state machine, elapsed-time
// tick counter and a reviewable lap buffer. o_time is a raw tick count
// that the display formatter splits into min/sec/centisec.
module stopwatch_lap_ctrl #(
    parameter int CNT_W         = 22,
    parameter int CNT_MAX       = 359999,
    parameter int LAP_AW        = 2,
    parameter int LAP_OVERWRITE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_tick,
    input  logic              i_btn_run,
    input  logic              i_btn_clear,
    input  logic              i_btn_lap,
    output logic              o_run,
    output logic              o_clear,
    output logic              o_lap_view,
    output logic [CNT_W-1:0]  o_time,
    output logic [LAP_AW-1:0] o_lap_idx,
    output logic [LAP_AW:0]   o_lap_count,
    output logic              o_lap_full
);

    localparam int LAP_DEPTH = 2 ** LAP_AW;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_VIEW  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [LAP_AW:0]   r_lap_count;
    logic [LAP_AW-1:0] r_wr_ptr;
    logic [LAP_AW-1:0] r_view_idx;
    logic [CNT_W-1:0]  r_mem [LAP_DEPTH];

    // Only the highest-priority button of a cycle is acted on: run > clear > lap.
    logic w_run, w_clear, w_lap;
    assign w_run   = i_btn_run;
    assign w_clear = i_btn_clear & ~i_btn_run;
    assign w_lap   = i_btn_lap & ~i_btn_run & ~i_btn_clear;

    logic w_full, w_has_laps, w_lap_wr, w_idx_last;
    assign w_full     = (r_lap_count == (LAP_AW + 1)'(LAP_DEPTH));
    assign w_has_laps = (r_lap_count != '0);
    // A lap press in RUN stores the counter unless the buffer is full and
    // configured to drop new laps.
    assign w_lap_wr   = (r_state == ST_RUN) && w_lap && (!w_full || (LAP_OVERWRITE != 0));
    assign w_idx_last = ((LAP_AW + 1)'(r_view_idx) == r_lap_count - 1'b1);

    // Oldest lap sits at wr_ptr once a circular buffer has wrapped, else at 0.
    logic [LAP_AW-1:0] w_base, w_phys;
    assign w_base = (w_full && (LAP_OVERWRITE != 0)) ? r_wr_ptr : '0;
    assign w_phys = w_base + r_view_idx;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (reset) r_state <= ST_STOP;
        else       r_state <= w_state_next;
    end

    // Next-state decode from the prioritised buttons.
    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            ST_STOP: begin
                if (w_run)                    w_state_next = ST_RUN;
                else if (w_clear)             w_state_next = ST_CLEAR;
                else if (w_lap && w_has_laps) w_state_next = ST_VIEW;
            end
            ST_RUN: begin
                if (w_run) w_state_next = ST_STOP;
            end
            ST_CLEAR: w_state_next = ST_STOP;
            ST_VIEW: begin
                if (w_run || w_clear) w_state_next = ST_STOP;
            end
            default: w_state_next = ST_STOP;
        endcase
    end

    // Elapsed-time counter, lap bookkeeping and view index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_lap_count <= '0;
            r_wr_ptr    <= '0;
            r_view_idx  <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_cnt <= '0;
            end else if (r_state == ST_RUN && i_tick) begin
                r_cnt <= (r_cnt == CNT_W'(CNT_MAX)) ? '0 : r_cnt + 1'b1;
            end

            if (r_state == ST_CLEAR) begin
                r_lap_count <= '0;
                r_wr_ptr    <= '0;
            end else if (w_lap_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (!w_full) r_lap_count <= r_lap_count + 1'b1;
            end

            // Index restarts at 0 whenever VIEW is entered or left.
            if (r_state != ST_VIEW || w_state_next != ST_VIEW) begin
                r_view_idx <= '0;
            end else if (w_lap) begin
                r_view_idx <= w_idx_last ? '0 : r_view_idx + 1'b1;
            end
        end
    end

    // Lap storage; the counter value before any same-cycle increment is stored.
    always_ff @(posedge clk) begin
        // NOTE: the lap entries are reset explicitly so a VIEW never shows stale
        // data after reset; this keeps the buffer in flops rather than a RAM macro.
        if (reset) begin
            for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_lap_wr) begin
            r_mem[r_wr_ptr] <= r_cnt;
        end
    end

    assign o_run       = (r_state == ST_RUN);
    assign o_clear     = (r_state == ST_CLEAR);
    assign o_lap_view  = (r_state == ST_VIEW);
    assign o_time      = (r_state == ST_VIEW) ? r_mem[w_phys] : r_cnt;
    assign o_lap_idx   = (r_state == ST_VIEW) ? r_view_idx : '0;
    assign o_lap_count = r_lap_count;
    assign o_lap_full  = w_full;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Scoreboard bench for stopwatch_lap_ctrl. Three instances share the
// stimulus: default configuration, CNT_MAX=9, and LAP_OVERWRITE=1.
module tb_stopwatch_lap_ctrl;

    localparam int D0 = 0;  // default parameters, drop-when-full
    localparam int D9 = 1;  // CNT_MAX = 9
    localparam int D1 = 2;  // LAP_OVERWRITE = 1

    localparam int F_TIME = 0, F_RUN = 1, F_CLEAR = 2, F_VIEW = 3,
                   F_IDX = 4, F_COUNT = 5, F_FULL = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0, btn_run = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;

    logic        run0, clr0, view0, full0;
    logic [21:0] time0;
    logic [1:0]  idx0;
    logic [2:0]  cnt0;
    logic        run9, clr9, view9, full9;
    logic [21:0] time9;
    logic [1:0]  idx9;
    logic [2:0]  cnt9;
    logic        run1, clr1, view1, full1;
    logic [21:0] time1;
    logic [1:0]  idx1;
    logic [2:0]  cnt1;

    stopwatch_lap_ctrl u_d0 (
        .clk(clk), .reset(reset), .i_tick(tick), .i_btn_run(btn_run),
        .i_btn_clear(btn_clear), .i_btn_lap(btn_lap), .o_run(run0),
        .o_clear(clr0), .o_lap_view(view0), .o_time(time0), .o_lap_idx(idx0),
        .o_lap_count(cnt0), .o_lap_full(full0)
    );

    stopwatch_lap_ctrl #(.CNT_MAX(9)) u_d9 (
        .clk(clk), .reset(reset), .i_tick(tick), .i_btn_run(btn_run),
        .i_btn_clear(btn_clear), .i_btn_lap(btn_lap), .o_run(run9),
        .o_clear(clr9), .o_lap_view(view9), .o_time(time9), .o_lap_idx(idx9),
        .o_lap_count(cnt9), .o_lap_full(full9)
    );

    stopwatch_lap_ctrl #(.LAP_OVERWRITE(1)) u_d1 (
        .clk(clk), .reset(reset), .i_tick(tick), .i_btn_run(btn_run),
        .i_btn_clear(btn_clear), .i_btn_lap(btn_lap), .o_run(run1),
        .o_clear(clr1), .o_lap_view(view1), .o_time(time1), .o_lap_idx(idx1),
        .o_lap_count(cnt1), .o_lap_full(full1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          dut;
        int          field;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] get_out(input int d, input int f);
        logic [31:0] v;
        v = '0;
        case (d)
            D0: case (f)
                F_TIME: v = 32'(time0);  F_RUN:   v = 32'(run0);
                F_CLEAR: v = 32'(clr0);  F_VIEW:  v = 32'(view0);
                F_IDX:  v = 32'(idx0);   F_COUNT: v = 32'(cnt0);
                default: v = 32'(full0);
            endcase
            D9: case (f)
                F_TIME: v = 32'(time9);  F_RUN:   v = 32'(run9);
                F_CLEAR: v = 32'(clr9);  F_VIEW:  v = 32'(view9);
                F_IDX:  v = 32'(idx9);   F_COUNT: v = 32'(cnt9);
                default: v = 32'(full9);
            endcase
            default: case (f)
                F_TIME: v = 32'(time1);  F_RUN:   v = 32'(run1);
                F_CLEAR: v = 32'(clr1);  F_VIEW:  v = 32'(view1);
                F_IDX:  v = 32'(idx1);   F_COUNT: v = 32'(cnt1);
                default: v = 32'(full1);
            endcase
        endcase
        return v;
    endfunction

    // Queue an expectation; it is checked after the next active clock edge.
    task automatic expect_out(input string n, input int d, input int f, input int unsigned v);
        exp_t e;
        e.name  = n;
        e.dut   = d;
        e.field = f;
        e.exp   = 32'(v);
        q.push_back(e);
    endtask

    task automatic expect_all_zero(input string n, input int d);
        for (int f = F_TIME; f <= F_FULL; f++) expect_out(n, d, f, 0);
    endtask

    // Drive one cycle of inputs from the falling edge.
    task automatic step(input logic rs, input logic tk, input logic rn,
                        input logic cl, input logic lp);
        @(negedge clk);
        reset     = rs;
        tick      = tk;
        btn_run   = rn;
        btn_clear = cl;
        btn_lap   = lp;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: shortly after each rising edge, compare every queued expectation.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = get_out(e.dut, e.field);
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s dut=%0d field=%0d got=%0d expected=%0d",
                             e.name, e.dut, e.field, act, e.exp);
                end
            end
        end
    end

    initial begin
        int unsigned v0 [4] = '{7, 12, 20, 3};
        int unsigned v1 [4] = '{12, 20, 25, 7};

        // Reset and idle ticks in STOP.
        step(1, 0, 0, 0, 0);
        expect_all_zero("reset_d0", D0);
        expect_all_zero("reset_d1", D1);
        ticks(5);
        expect_out("stop_ticks_time", D0, F_TIME, 0);
        expect_out("stop_ticks_run", D0, F_RUN, 0);
        step(0, 0, 1, 0, 0);
        expect_out("run_on", D0, F_RUN, 1);
        for (int i = 1; i <= 5; i++) begin
            ticks(1);
            expect_out("run_count", D0, F_TIME, i);
        end
        step(0, 0, 1, 0, 0);
        expect_out("run_off", D0, F_RUN, 0);
        ticks(3);
        expect_out("frozen_time", D0, F_TIME, 5);

        // Counter wrap at CNT_MAX = 9.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            ticks(1);
            expect_out("wrap_seq", D9, F_TIME, i % 10);
        end

        // Lap recording at 3, 7, 12, 20, 25.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(3);
        step(0, 0, 0, 0, 1);
        expect_out("lap1_count", D0, F_COUNT, 1);
        ticks(4);  step(0, 0, 0, 0, 1);
        ticks(5);  step(0, 0, 0, 0, 1);
        ticks(8);  step(0, 0, 0, 0, 1);
        expect_out("lap4_full", D0, F_FULL, 1);
        ticks(5);  step(0, 0, 0, 0, 1);
        expect_out("lap5_count_d0", D0, F_COUNT, 4);
        expect_out("lap5_full_d0", D0, F_FULL, 1);
        expect_out("lap5_count_d1", D1, F_COUNT, 4);
        expect_out("lap5_full_d1", D1, F_FULL, 1);
        expect_out("lap5_time", D0, F_TIME, 25);
        // Tick in the run-to-STOP cycle still counts.
        step(0, 1, 1, 0, 0);
        expect_out("stop_tick_run", D0, F_RUN, 0);
        expect_out("stop_tick_time", D0, F_TIME, 26);

        // Enter VIEW and step through the laps.
        step(0, 0, 0, 0, 1);
        expect_out("view_on", D0, F_VIEW, 1);
        expect_out("view_idx0", D0, F_IDX, 0);
        expect_out("view0_d0", D0, F_TIME, 3);
        expect_out("view0_d1", D1, F_TIME, 7);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            expect_out("view_step_d0", D0, F_TIME, v0[i]);
            expect_out("view_step_d1", D1, F_TIME, v1[i]);
            expect_out("view_step_idx", D0, F_IDX, (i + 1) % 4);
        end
        step(0, 0, 1, 0, 0);
        expect_out("view_exit", D0, F_VIEW, 0);
        expect_out("view_exit_run", D0, F_RUN, 0);
        expect_out("view_exit_idx", D0, F_IDX, 0);
        expect_out("view_exit_time", D0, F_TIME, 26);
        ticks(1);
        expect_out("after_view_frozen", D0, F_TIME, 26);

        // Clear from STOP.
        step(0, 0, 0, 1, 0);
        expect_out("clear_pulse", D0, F_CLEAR, 1);
        expect_out("clear_run", D0, F_RUN, 0);
        step(0, 0, 0, 0, 0);
        expect_out("clear_done", D0, F_CLEAR, 0);
        expect_out("clear_time", D0, F_TIME, 0);
        expect_out("clear_count_d0", D0, F_COUNT, 0);
        expect_out("clear_full_d1", D1, F_FULL, 0);

        // Buttons during CLEAR are ignored.
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        expect_out("in_clear_run_ignored", D0, F_RUN, 0);
        expect_out("in_clear_exit", D0, F_CLEAR, 0);
        step(0, 0, 0, 0, 0);
        expect_out("after_clear_stop", D0, F_RUN, 0);

        // Lap in STOP with no laps stays in STOP.
        step(0, 0, 0, 0, 1);
        expect_out("lap_empty_no_view", D0, F_VIEW, 0);

        // Clear during RUN is ignored.
        step(0, 0, 1, 0, 0);
        ticks(2);
        step(0, 0, 0, 1, 0);
        expect_out("run_clear_ignored", D0, F_CLEAR, 0);
        expect_out("run_clear_still_run", D0, F_RUN, 1);
        expect_out("run_clear_time", D0, F_TIME, 2);
        step(0, 0, 0, 0, 0);
        expect_out("run_clear_no_clear", D0, F_CLEAR, 0);

        // Simultaneous run+clear+lap in STOP goes to RUN.
        step(0, 0, 1, 0, 0);
        expect_out("stop_again", D0, F_RUN, 0);
        step(0, 0, 1, 1, 1);
        expect_out("multi_run", D0, F_RUN, 1);
        expect_out("multi_clear", D0, F_CLEAR, 0);
        expect_out("multi_view", D0, F_VIEW, 0);

        // Reset overrides tick and run in RUN.
        ticks(1);
        step(1, 1, 1, 0, 0);
        expect_all_zero("reset_in_run", D0);
        step(0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
